// File: rtl/ro_trng_sampler.sv
// Ring-oscillator TRNG sampler: synchronises a fast/slow oscillator pair, samples
// the fast one on each slow rising edge, optionally von Neumann debiases the raw
// stream, packs bits into words and runs a repetition-count health test.
module ro_trng_sampler #(
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned DEBIAS    = 1,
  parameter int unsigned RCT_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             osc_a,
  input  logic             osc_b,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  input  logic             clr_flags,
  output logic             overrun,
  output logic             health_fail
);

  localparam int unsigned     CntW      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(OUT_W - 1);
  localparam logic [7:0]      RctLim    = 8'(RCT_LIMIT);
  localparam bit              UseDebias = (DEBIAS != 0);

  typedef enum logic {StWaitFirst, StHaveFirst} pair_st_e;

  logic             a_meta_q, a_meta_d, a_s_q, a_s_d;
  logic             b_meta_q, b_meta_d, b_s_q, b_s_d, b_d_q, b_d_d;
  pair_st_e         state_q, state_d;
  logic             first_q, first_d;
  logic [OUT_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       run_q, run_d;
  logic             last_q, last_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             hf_q, hf_d;

  logic             strobe, raw, acc, acc_bit, complete;
  logic [OUT_W-1:0] word;

  assign strobe = b_s_q & ~b_d_q;
  assign raw    = a_s_q;

  // Next-state: synchronisers, pair FSM, word assembly, handshake, health test.
  always_comb begin
    a_meta_d = osc_a;
    a_s_d    = a_meta_q;
    b_meta_d = osc_b;
    b_s_d    = b_meta_q;
    b_d_d    = b_s_q;
    state_d  = state_q;
    first_d  = first_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    last_d   = last_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q & ~clr_flags;
    hf_d     = hf_q & ~clr_flags;
    acc      = 1'b0;
    acc_bit  = 1'b0;
    complete = 1'b0;
    word     = shift_q;

    if (!en) begin
      // Disabling abandons any partial pair/word and restarts the run count.
      state_d = StWaitFirst;
      shift_d = '0;
      cnt_d   = '0;
      run_d   = '0;
    end else if (strobe) begin
      // Health test sees raw bits before debiasing.
      if (run_q == 8'd0 || raw != last_q) begin
        run_d = 8'd1;
      end else if (run_q < RctLim) begin
        run_d = run_q + 8'd1;
      end
      last_d = raw;
      if (run_d == RctLim) begin
        hf_d = 1'b1;
      end

      if (UseDebias) begin
        if (state_q == StWaitFirst) begin
          first_d = raw;
          state_d = StHaveFirst;
        end else begin
          state_d = StWaitFirst;
          // 01 -> 0, 10 -> 1: the accepted bit equals the first of the pair.
          if (first_q != raw) begin
            acc     = 1'b1;
            acc_bit = first_q;
          end
        end
      end else begin
        acc     = 1'b1;
        acc_bit = raw;
      end
    end

    if (acc) begin
      word    = {shift_q[OUT_W-2:0], acc_bit};
      shift_d = word;
      if (cnt_q == CntLast) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (complete && (!valid_q || data_ready)) begin
      dout_d  = word;
      valid_d = 1'b1;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_meta_q <= 1'b0;
      a_s_q    <= 1'b0;
      b_meta_q <= 1'b0;
      b_s_q    <= 1'b0;
      b_d_q    <= 1'b0;
      state_q  <= StWaitFirst;
      first_q  <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      run_q    <= '0;
      last_q   <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      hf_q     <= 1'b0;
    end else begin
      a_meta_q <= a_meta_d;
      a_s_q    <= a_s_d;
      b_meta_q <= b_meta_d;
      b_s_q    <= b_s_d;
      b_d_q    <= b_d_d;
      state_q  <= state_d;
      first_q  <= first_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      last_q   <= last_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      hf_q     <= hf_d;
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign overrun     = ovr_q;
  assign health_fail = hf_q;

endmodule

// File: tb/tb_ro_trng_sampler.sv
// Scoreboard bench for ro_trng_sampler: one raw (DEBIAS=0) and one debiased
// (DEBIAS=1) instance share stimulus; a monitor checks delivered words.
module tb_ro_trng_sampler;

  logic clk = 1'b0;
  logic rst_n, en, osc_a, osc_b, data_ready, clr_flags;
  logic [7:0] raw_dout, vn_dout;
  logic raw_valid, vn_valid, raw_ovr, vn_ovr, raw_hf, vn_hf;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic mon_vn = 1'b0;

  always #5 clk = ~clk;

  ro_trng_sampler #(.OUT_W(8), .DEBIAS(0), .RCT_LIMIT(32)) u_raw (
    .clk(clk), .rst_n(rst_n), .en(en), .osc_a(osc_a), .osc_b(osc_b),
    .data_out(raw_dout), .data_valid(raw_valid), .data_ready(data_ready),
    .clr_flags(clr_flags), .overrun(raw_ovr), .health_fail(raw_hf)
  );

  ro_trng_sampler #(.OUT_W(8), .DEBIAS(1), .RCT_LIMIT(32)) u_vn (
    .clk(clk), .rst_n(rst_n), .en(en), .osc_a(osc_a), .osc_b(osc_b),
    .data_out(vn_dout), .data_valid(vn_valid), .data_ready(data_ready),
    .clr_flags(clr_flags), .overrun(vn_ovr), .health_fail(vn_hf)
  );

  // Monitor: every handshake on the selected instance pops one expected word.
  always @(negedge clk) begin
    logic       v;
    logic [7:0] d;
    logic [7:0] e;
    #1;
    v = mon_vn ? vn_valid : raw_valid;
    d = mon_vn ? vn_dout : raw_dout;
    if (v === 1'b1 && data_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL word_unexpected: got %02h, required no word", d);
      end else begin
        e = exp_q.pop_front();
        if (d !== e) begin
          n_err++;
          $display("FAIL word: got %02h, required %02h", d, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; osc_a = 1'b0; osc_b = 1'b0;
    data_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One osc_b rising edge carrying raw bit a; takes effect 3 clk later.
  // With clr set, clr_flags is high in exactly that effect cycle.
  task automatic strobe(input logic a, input logic clr = 1'b0);
    @(negedge clk);
    osc_a = a; osc_b = 1'b1;
    repeat (2) @(negedge clk);
    clr_flags = clr;
    @(negedge clk);
    clr_flags = 1'b0; osc_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pair(input logic [1:0] p);
    strobe(p[1]);
    strobe(p[0]);
  endtask

  logic [1:0] pairs_a[11];
  logic [1:0] pairs_b[8];

  initial begin
    rst_n = 1'b0; en = 1'b0; osc_a = 1'b0; osc_b = 1'b0;
    data_ready = 1'b0; clr_flags = 1'b0;

    // Reset state of both instances.
    do_reset();
    chk("rst_raw_dout", raw_dout, 0);
    chk("rst_raw_valid", raw_valid, 0);
    chk("rst_raw_ovr", raw_ovr, 0);
    chk("rst_raw_hf", raw_hf, 0);
    chk("rst_vn_dout", vn_dout, 0);
    chk("rst_vn_valid", vn_valid, 0);
    chk("rst_vn_ovr", vn_ovr, 0);
    chk("rst_vn_hf", vn_hf, 0);

    // Raw mode, constant 1: eight strobes give FF, held while not ready.
    mon_vn = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) strobe(1'b1);
    chk("ones_dout", raw_dout, 8'hFF);
    chk("ones_valid", raw_valid, 1);
    chk("ones_hf", raw_hf, 0);
    exp_q.push_back(8'hFF);
    data_ready = 1'b1;
    @(negedge clk);
    chk("ones_valid_drop", raw_valid, 0);
    chk("ones_q_empty", exp_q.size(), 0);

    // Debiased: accepted bits 0,1,1,0,0,1,1,0 complete 8'h66 on the 10th pair;
    // the 11th pair's bit starts the next word.
    mon_vn = 1'b1;
    do_reset();
    data_ready = 1'b1;
    pairs_a = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
    exp_q.push_back(8'h66);
    for (int i = 0; i < 11; i++) send_pair(pairs_a[i]);
    chk("vn_q_empty", exp_q.size(), 0);
    chk("vn_valid_after", vn_valid, 0);
    chk("vn_dout_held", vn_dout, 8'h66);

    // Raw alternating bits with no consumer: second word is dropped.
    mon_vn = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) strobe(i[0]);
    chk("ovr_before", raw_ovr, 0);
    strobe(1'b1);
    chk("ovr_set", raw_ovr, 1);
    chk("ovr_dout", raw_dout, 8'h55);
    chk("ovr_valid", raw_valid, 1);
    chk("ovr_hf", raw_hf, 0);
    exp_q.push_back(8'h55);
    data_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_drop", raw_valid, 0);
    chk("ovr_dout_hold", raw_dout, 8'h55);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("ovr_cleared", raw_ovr, 0);

    // Reset after 5 accepted bits discards them.
    for (int i = 0; i < 5; i++) strobe(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_dout", raw_dout, 0);
    chk("mid_rst_valid", raw_valid, 0);
    chk("mid_rst_ovr", raw_ovr, 0);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 7; i++) strobe(1'b1);
    chk("mid_rst_no_word", raw_valid, 0);
    chk("mid_rst_pending", exp_q.size(), 1);
    strobe(1'b1);
    chk("mid_rst_q_empty", exp_q.size(), 0);

    // Repetition count: 32 zeros trip health_fail; clear loses to a set.
    do_reset();
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 31; i++) strobe(1'b0);
    chk("hf_before", raw_hf, 0);
    strobe(1'b0);
    chk("hf_set", raw_hf, 1);
    strobe(1'b0, 1'b1);
    chk("hf_clr_vs_set", raw_hf, 1);
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("hf_cleared", raw_hf, 0);
    chk("hf_ovr", raw_ovr, 0);
    chk("hf_q_empty", exp_q.size(), 0);

    // Disable while holding a first bit: next raw bit opens a new pair.
    mon_vn = 1'b1;
    do_reset();
    data_ready = 1'b1;
    strobe(1'b0);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    pairs_b = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 8; i++) send_pair(pairs_b[i]);
    chk("en_q_empty", exp_q.size(), 0);
    chk("en_dout", vn_dout, 8'hAA);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
